// File: rtl/traffic_demand_model.sv
// rtl/traffic_demand_model.sv - closed-loop car/pedestrian demand model for the traffic-light controller
//
// Purpose: holds per-direction queues of waiting cars and pedestrians, fed by
// arrival edges and drained on the 1 Hz tick while the matching light shows
// green or walk. Drives the controller's request inputs, flags starvation,
// and latches a sticky fault on conflicting or malformed light codes.
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   tick                             one-clk 1 Hz strobe gating departures and wait counting
//   arrive_ns/arrive_ew/arrive_ped   debounced levels, rising edge = one arrival
//   light_ns/light_ew [2:0]          {red, yellow, green}
//   light_ped [1:0]                  {dont_walk, walk}
//   car_ns/car_ew/ped                queue non-empty requests
//   q_ns/q_ew/q_ped [QW-1:0]         queue occupancy
//   starve_ns/starve_ew/starve_ped   wait counter reached STARVE_LIMIT
//   fault                            sticky safety violation

module traffic_demand_model #(
  parameter int QW           = 4,
  parameter int WW           = 6,
  parameter int STARVE_LIMIT = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          arrive_ns,
  input  logic          arrive_ew,
  input  logic          arrive_ped,
  input  logic [2:0]    light_ns,
  input  logic [2:0]    light_ew,
  input  logic [1:0]    light_ped,
  output logic          car_ns,
  output logic          car_ew,
  output logic          ped,
  output logic [QW-1:0] q_ns,
  output logic [QW-1:0] q_ew,
  output logic [QW-1:0] q_ped,
  output logic          starve_ns,
  output logic          starve_ew,
  output logic          starve_ped,
  output logic          fault
);

  localparam logic [QW-1:0] Q_FULL    = {QW{1'b1}};
  localparam logic [QW-1:0] Q_ONE     = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] W_ONE     = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] W_LIMIT   = STARVE_LIMIT[WW-1:0];
  localparam logic [2:0]    CAR_GREEN = 3'b001;
  localparam logic [1:0]    PED_WALK  = 2'b01;
  localparam logic [1:0]    PED_BAD   = 2'b11;

  logic          prev_ns, prev_ew, prev_ped;
  logic [WW-1:0] wait_ns, wait_ew, wait_ped;

  logic          arr_ns, arr_ew, arr_ped;
  logic          serve_ns, serve_ew, serve_ped;
  logic          dep_ns, dep_ew;
  logic [QW-1:0] q_ns_next, q_ew_next, q_ped_next;
  logic [WW-1:0] wait_ns_next, wait_ew_next, wait_ped_next;
  logic          nonred_ns, nonred_ew;
  logic          violation;

  // prev_* resets high so a level already asserted at reset release is not
  // mistaken for a fresh arrival.
  assign arr_ns  = arrive_ns  & ~prev_ns;
  assign arr_ew  = arrive_ew  & ~prev_ew;
  assign arr_ped = arrive_ped & ~prev_ped;

  // Only the exact green / walk codes serve a queue; yellow never drains.
  assign serve_ns  = (light_ns  == CAR_GREEN);
  assign serve_ew  = (light_ew  == CAR_GREEN);
  assign serve_ped = (light_ped == PED_WALK);

  assign dep_ns = tick & serve_ns & (q_ns != '0);
  assign dep_ew = tick & serve_ew & (q_ew != '0);

  // Car queues: an arrival paired with a departure cancels out, so a full
  // queue stays full in that case; a lone arrival into a full queue is lost.
  always_comb begin
    q_ns_next = q_ns;
    if (arr_ns && !dep_ns) begin
      if (q_ns != Q_FULL) q_ns_next = q_ns + Q_ONE;
    end else if (dep_ns && !arr_ns) begin
      q_ns_next = q_ns - Q_ONE;
    end
  end

  always_comb begin
    q_ew_next = q_ew;
    if (arr_ew && !dep_ew) begin
      if (q_ew != Q_FULL) q_ew_next = q_ew + Q_ONE;
    end else if (dep_ew && !arr_ew) begin
      q_ew_next = q_ew - Q_ONE;
    end
  end

  // Pedestrians all cross together; someone arriving at that instant is
  // left behind as the sole waiter.
  always_comb begin
    q_ped_next = q_ped;
    if (tick && serve_ped) begin
      q_ped_next = arr_ped ? Q_ONE : '0;
    end else if (arr_ped && (q_ped != Q_FULL)) begin
      q_ped_next = q_ped + Q_ONE;
    end
  end

  // Wait counters judge the queue as it stood before this edge, and clear on
  // any clk (not only ticks) once the queue is empty or being served.
  always_comb begin
    wait_ns_next = wait_ns;
    if ((q_ns == '0) || serve_ns)           wait_ns_next = '0;
    else if (tick && (wait_ns != W_LIMIT))  wait_ns_next = wait_ns + W_ONE;
  end

  always_comb begin
    wait_ew_next = wait_ew;
    if ((q_ew == '0) || serve_ew)           wait_ew_next = '0;
    else if (tick && (wait_ew != W_LIMIT))  wait_ew_next = wait_ew + W_ONE;
  end

  always_comb begin
    wait_ped_next = wait_ped;
    if ((q_ped == '0) || serve_ped)          wait_ped_next = '0;
    else if (tick && (wait_ped != W_LIMIT))  wait_ped_next = wait_ped + W_ONE;
  end

  // Non-red means green or yellow lit; a dark (all-zero) head counts as red.
  assign nonred_ns = light_ns[0] | light_ns[1];
  assign nonred_ew = light_ew[0] | light_ew[1];

  // x & (x-1) is non-zero exactly when more than one bit is set.
  always_comb begin
    violation = 1'b0;
    if (|(light_ns & (light_ns - 3'd1)))        violation = 1'b1;
    if (|(light_ew & (light_ew - 3'd1)))        violation = 1'b1;
    if (light_ped == PED_BAD)                   violation = 1'b1;
    if (nonred_ns && nonred_ew)                 violation = 1'b1;
    if (light_ped[0] && (nonred_ns || nonred_ew)) violation = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ns  <= 1'b1;
      prev_ew  <= 1'b1;
      prev_ped <= 1'b1;
      q_ns     <= '0;
      q_ew     <= '0;
      q_ped    <= '0;
      wait_ns  <= '0;
      wait_ew  <= '0;
      wait_ped <= '0;
      fault    <= 1'b0;
    end else begin
      prev_ns  <= arrive_ns;
      prev_ew  <= arrive_ew;
      prev_ped <= arrive_ped;
      q_ns     <= q_ns_next;
      q_ew     <= q_ew_next;
      q_ped    <= q_ped_next;
      wait_ns  <= wait_ns_next;
      wait_ew  <= wait_ew_next;
      wait_ped <= wait_ped_next;
      fault    <= fault | violation;
    end
  end

  assign car_ns = (q_ns  != '0);
  assign car_ew = (q_ew  != '0);
  assign ped    = (q_ped != '0);

  assign starve_ns  = (wait_ns  == W_LIMIT);
  assign starve_ew  = (wait_ew  == W_LIMIT);
  assign starve_ped = (wait_ped == W_LIMIT);

endmodule

// File: tb/tb_traffic_demand_model.sv
// tb/tb_traffic_demand_model.sv - self-checking bench for traffic_demand_model

module tb_traffic_demand_model;

  localparam int QMAX = 15;
  localparam int SL   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       arrive_ns = 1'b0, arrive_ew = 1'b0, arrive_ped = 1'b0;
  logic [2:0] light_ns = 3'b100, light_ew = 3'b100;
  logic [1:0] light_ped = 2'b10;
  logic       car_ns, car_ew, ped;
  logic [3:0] q_ns, q_ew, q_ped;
  logic       starve_ns, starve_ew, starve_ped;
  logic       fault;

  int checks = 0;
  int errors = 0;

  int m_q[3];
  int m_wait[3];
  bit m_prev[3];
  bit m_fault;

  traffic_demand_model #(.QW(4), .WW(6), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .arrive_ns(arrive_ns), .arrive_ew(arrive_ew), .arrive_ped(arrive_ped),
    .light_ns(light_ns), .light_ew(light_ew), .light_ped(light_ped),
    .car_ns(car_ns), .car_ew(car_ew), .ped(ped),
    .q_ns(q_ns), .q_ew(q_ew), .q_ped(q_ped),
    .starve_ns(starve_ns), .starve_ew(starve_ew), .starve_ped(starve_ped),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference: what the intersection should look like after one clk, written
  // as counts of waiting people and elapsed ticks.
  task automatic model_update();
    int  a[3];
    bit  served[3];
    bit  viol;
    bit  nr_ns, nr_ew;
    if (rst) begin
      m_q = '{0, 0, 0};
      m_wait = '{0, 0, 0};
      m_prev = '{1, 1, 1};
      m_fault = 0;
      return;
    end
    a[0] = (arrive_ns  && !m_prev[0]) ? 1 : 0;
    a[1] = (arrive_ew  && !m_prev[1]) ? 1 : 0;
    a[2] = (arrive_ped && !m_prev[2]) ? 1 : 0;
    served[0] = (light_ns == 3'b001);
    served[1] = (light_ew == 3'b001);
    served[2] = (light_ped == 2'b01);
    for (int i = 0; i < 3; i++) begin
      int nq;
      int nw;
      if (m_q[i] == 0 || served[i]) nw = 0;
      else if (tick) nw = (m_wait[i] + 1 > SL) ? SL : m_wait[i] + 1;
      else nw = m_wait[i];
      if (i < 2) begin
        nq = m_q[i] + a[i] - ((tick && served[i] && m_q[i] > 0) ? 1 : 0);
      end else if (tick && served[i]) begin
        nq = a[i];
      end else begin
        nq = m_q[i] + a[i];
      end
      if (nq > QMAX) nq = QMAX;
      m_q[i] = nq;
      m_wait[i] = nw;
    end
    nr_ns = (light_ns & 3'b011) != 0;
    nr_ew = (light_ew & 3'b011) != 0;
    viol = ($countones(light_ns) > 1) || ($countones(light_ew) > 1) ||
           (light_ped == 2'b11) || (nr_ns && nr_ew) ||
           (light_ped[0] && (nr_ns || nr_ew));
    if (viol) m_fault = 1;
    m_prev[0] = arrive_ns;
    m_prev[1] = arrive_ew;
    m_prev[2] = arrive_ped;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic all_red();
    light_ns = 3'b100; light_ew = 3'b100; light_ped = 2'b10;
  endtask

  task automatic do_reset();
    arrive_ns = 0; arrive_ew = 0; arrive_ped = 0; tick = 0;
    all_red();
    rst = 1; step(); rst = 0; step();
  endtask

  task automatic test_reset();
    arrive_ns = 1; arrive_ew = 1; arrive_ped = 1; tick = 0;
    all_red();
    rst = 1; step(); step(); rst = 0;
    repeat (5) step();
    checks++;
    if ({q_ns, q_ew, q_ped} !== 12'h000) begin
      errors++; $display("FAIL reset_queues: got %h expected 000", {q_ns, q_ew, q_ped});
    end
    checks++;
    if ({car_ns, car_ew, ped} !== 3'b000) begin
      errors++; $display("FAIL reset_requests: got %b expected 000", {car_ns, car_ew, ped});
    end
    checks++;
    if ({fault, starve_ns, starve_ew, starve_ped} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {fault, starve_ns, starve_ew, starve_ped});
    end
  endtask

  task automatic test_arrivals_drain();
    int exp_q[4] = '{2, 1, 0, 0};
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      arrive_ns = 1; step();
      checks++;
      if (q_ns !== 4'(i) || car_ns !== 1'b1) begin
        errors++; $display("FAIL arrival_%0d: got q=%0d car=%b expected q=%0d car=1", i, q_ns, car_ns, i);
      end
      arrive_ns = 0; step();
    end
    light_ns = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick = 1; step(); tick = 0;
      checks++;
      if (q_ns !== 4'(exp_q[i]) || car_ns !== (exp_q[i] != 0)) begin
        errors++; $display("FAIL drain_tick_%0d: got q=%0d car=%b expected q=%0d", i + 1, q_ns, car_ns, exp_q[i]);
      end
      step();
      checks++;
      if (q_ns !== 4'(exp_q[i])) begin
        errors++; $display("FAIL no_drain_between_ticks_%0d: got %0d expected %0d", i + 1, q_ns, exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      arrive_ew = 1; step(); arrive_ew = 0; step();
      checks++;
      if (q_ew !== 4'((i > QMAX) ? QMAX : i)) begin
        errors++; $display("FAIL sat_arrival_%0d: got %0d expected %0d", i, q_ew, (i > QMAX) ? QMAX : i);
      end
    end
    light_ew = 3'b001; arrive_ew = 1; tick = 1; step(); tick = 0; arrive_ew = 0;
    checks++;
    if (q_ew !== 4'd15) begin
      errors++; $display("FAIL sat_coincident: got %0d expected 15", q_ew);
    end
  endtask

  task automatic test_ped_crossing();
    do_reset();
    repeat (4) begin arrive_ped = 1; step(); arrive_ped = 0; step(); end
    checks++;
    if (q_ped !== 4'd4 || ped !== 1'b1) begin
      errors++; $display("FAIL ped_queue: got q=%0d ped=%b expected 4/1", q_ped, ped);
    end
    light_ped = 2'b01; tick = 1; step(); tick = 0;
    checks++;
    if (q_ped !== 4'd0 || ped !== 1'b0) begin
      errors++; $display("FAIL ped_cross: got q=%0d ped=%b expected 0/0", q_ped, ped);
    end
    light_ped = 2'b10;
    repeat (4) begin arrive_ped = 1; step(); arrive_ped = 0; step(); end
    light_ped = 2'b01; arrive_ped = 1; tick = 1; step(); tick = 0; arrive_ped = 0;
    checks++;
    if (q_ped !== 4'd1) begin
      errors++; $display("FAIL ped_cross_coincident: got %0d expected 1", q_ped);
    end
    light_ped = 2'b10;
  endtask

  task automatic test_starvation();
    do_reset();
    arrive_ns = 1; step(); arrive_ns = 0; step();
    for (int t = 1; t <= SL; t++) begin
      tick = 1; step(); tick = 0;
      checks++;
      if (starve_ns !== (t == SL)) begin
        errors++; $display("FAIL starve_tick_%0d: got %b expected %b", t, starve_ns, t == SL);
      end
      step();
    end
    light_ns = 3'b001; step();
    checks++;
    if (starve_ns !== 1'b0 || q_ns !== 4'd1) begin
      errors++; $display("FAIL starve_clear: got starve=%b q=%0d expected 0/1", starve_ns, q_ns);
    end
  endtask

  task automatic test_faults();
    logic [7:0] bad[3] = '{8'b001_010_10, 8'b100_100_11, 8'b011_100_10};
    do_reset();
    light_ns = 3'b000; light_ew = 3'b000; light_ped = 2'b00;
    repeat (3) step();
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL fault_dark_legal: got %b expected 0", fault);
    end
    for (int i = 0; i < 3; i++) begin
      do_reset();
      {light_ns, light_ew, light_ped} = bad[i];
      step();
      all_red();
      checks++;
      if (fault !== 1'b1) begin
        errors++; $display("FAIL fault_set_%0d: got %b expected 1", i, fault);
      end
      repeat (3) step();
      checks++;
      if (fault !== 1'b1) begin
        errors++; $display("FAIL fault_sticky_%0d: got %b expected 1", i, fault);
      end
      rst = 1; step(); rst = 0;
      checks++;
      if (fault !== 1'b0) begin
        errors++; $display("FAIL fault_reset_%0d: got %b expected 0", i, fault);
      end
    end
  endtask

  task automatic set_phase(input int p);
    all_red();
    case (p)
      0: light_ns = 3'b001;
      1: light_ns = 3'b010;
      2: light_ew = 3'b001;
      3: light_ew = 3'b010;
      4: light_ped = 2'b01;
      5: ;
      default: begin light_ns = 3'b000; light_ew = 3'b000; light_ped = 2'b00; end
    endcase
  endtask

  task automatic test_random();
    int phase = 5;
    do_reset();
    set_phase(phase);
    for (int c = 0; c < 4000; c++) begin
      arrive_ns  = ($urandom_range(0, 3) == 0) ? ~arrive_ns  : arrive_ns;
      arrive_ew  = ($urandom_range(0, 3) == 0) ? ~arrive_ew  : arrive_ew;
      arrive_ped = ($urandom_range(0, 3) == 0) ? ~arrive_ped : arrive_ped;
      tick = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 79) == 0) phase = $urandom_range(0, 6);
      set_phase(phase);
      if ($urandom_range(0, 399) == 0) begin
        light_ns = 3'($urandom); light_ew = 3'($urandom); light_ped = 2'($urandom);
      end
      step();
      checks++;
      if ({q_ns, q_ew, q_ped} !== {4'(m_q[0]), 4'(m_q[1]), 4'(m_q[2])}) begin
        errors++; $display("FAIL rand_queues cyc %0d: got %h expected %h", c, {q_ns, q_ew, q_ped},
                           {4'(m_q[0]), 4'(m_q[1]), 4'(m_q[2])});
      end
      checks++;
      if ({car_ns, car_ew, ped, starve_ns, starve_ew, starve_ped, fault} !==
          {m_q[0] != 0, m_q[1] != 0, m_q[2] != 0, m_wait[0] == SL, m_wait[1] == SL, m_wait[2] == SL, m_fault}) begin
        errors++; $display("FAIL rand_flags cyc %0d: got %b expected %b", c,
                           {car_ns, car_ew, ped, starve_ns, starve_ew, starve_ped, fault},
                           {m_q[0] != 0, m_q[1] != 0, m_q[2] != 0, m_wait[0] == SL, m_wait[1] == SL, m_wait[2] == SL, m_fault});
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_arrivals_drain();
    test_saturation();
    test_ped_crossing();
    test_starvation();
    test_faults();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
